// File: rtl/lane_sched_pkg.sv
// Shared types and width helpers for the round-robin lane scheduler.
//   state_e    : scheduler FSM states (idle / burst in progress)
//   lane_w()   : width of a lane index for n lanes (at least 1)
//   cnt_w()    : width of the beat counter for a given max burst length (at least 1)
package lane_sched_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    function automatic int unsigned lane_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_beats);
        return (max_beats <= 2) ? 1 : $clog2(max_beats);
    endfunction

    localparam int unsigned DefN        = 10;
    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefMaxBeats = 16;
    localparam int unsigned DefLaneW    = lane_w(DefN);
    localparam int unsigned DefCntW     = cnt_w(DefMaxBeats);

endpackage

// File: rtl/lane_rr_scheduler_if.sv
// Requester/resource bundle of the lane scheduler.
//   i_req   : per-lane request/valid          i_last : per-lane final-beat marker
//   i_data  : per-lane data                   i_ready: shared resource accepts a beat
//   o_grant : one-hot grant or zero           o_valid: beat presented to the resource
//   o_data  : data of the granted lane        o_lane : granted lane index
//   o_busy  : a burst is in progress
// master = requesters + resource side, slave = scheduler side.
interface lane_rr_scheduler_if
    import lane_sched_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned WIDTH = DefWidth
);
    localparam int unsigned LaneW = lane_w(N);

    logic [N-1:0]            i_req;
    logic [N-1:0]            i_last;
    logic [N-1:0][WIDTH-1:0] i_data;
    logic                    i_ready;
    logic [N-1:0]            o_grant;
    logic                    o_valid;
    logic [WIDTH-1:0]        o_data;
    logic [LaneW-1:0]        o_lane;
    logic                    o_busy;

    modport master (
        output i_req, i_last, i_data, i_ready,
        input  o_grant, o_valid, o_data, o_lane, o_busy
    );

    modport slave (
        input  i_req, i_last, i_data, i_ready,
        output o_grant, o_valid, o_data, o_lane, o_busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder.
//   req_i   : request vector
//   ptr_i   : last winner; lanes ptr+1, ptr+2, ... (mod N) are scanned, ptr itself last
//   valid_o : any request present
//   idx_o   : index of the first requester in scan order
module rr_pick #(
    parameter int unsigned N     = 10,
    parameter int unsigned LaneW = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [LaneW-1:0] ptr_i,
    output logic             valid_o,
    output logic [LaneW-1:0] idx_o
);

    always_comb begin : p_scan
        logic [LaneW-1:0] cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Scan from farthest to nearest so the nearest hit is the one left standing.
        for (int unsigned k = N; k >= 1; k--) begin
            cand = LaneW'((32'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/lane_rr_scheduler.sv
// Round-robin burst scheduler: N requester lanes share one resource.
//   i_clk : clock            i_rst : synchronous active-high reset
//   bus   : slave modport of lane_rr_scheduler_if (requests, data, grant, beat handshake)
// A lane wins in IDLE, owns the resource for a burst that ends on i_last or after
// MAX_BEATS transfers, then the pointer moves to it so it has lowest priority next.
module lane_rr_scheduler
    import lane_sched_pkg::*;
#(
    parameter int unsigned N         = DefN,
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned MAX_BEATS = DefMaxBeats
) (
    input logic                i_clk,
    input logic                i_rst,
    lane_rr_scheduler_if.slave bus
);

    localparam int unsigned      LaneW   = lane_w(N);
    localparam int unsigned      CntW    = cnt_w(MAX_BEATS);
    localparam logic [CntW-1:0]  LastCnt = CntW'(MAX_BEATS - 1);
    localparam logic [LaneW-1:0] PtrRst  = LaneW'(N - 1);

    state_e           state_q;
    logic [LaneW-1:0] ptr_q;
    logic [LaneW-1:0] lane_q;
    logic [CntW-1:0]  cnt_q;
    logic [N-1:0]     grant_q;

    logic             pick_valid;
    logic [LaneW-1:0] pick_idx;

    rr_pick #(
        .N     (N),
        .LaneW (LaneW)
    ) u_pick (
        .req_i   (bus.i_req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Per-lane qualification by the one-hot grant; OR-reduced below.
    logic [N-1:0]            lane_req;
    logic [N-1:0]            lane_last;
    logic [N-1:0][WIDTH-1:0] lane_data;

    for (genvar i = 0; i < N; i++) begin : gen_lane
        assign lane_req[i]  = grant_q[i] & bus.i_req[i];
        assign lane_last[i] = grant_q[i] & bus.i_last[i];
        assign lane_data[i] = grant_q[i] ? bus.i_data[i] : '0;
    end

    logic [WIDTH-1:0] sel_data;

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_data = sel_data | lane_data[i];
        end
    end

    logic busy;
    logic beat_valid;
    logic xfer;
    logic rel_burst;

    assign busy       = (state_q == StBusy);
    assign beat_valid = busy & (|lane_req);
    assign xfer       = beat_valid & bus.i_ready;
    assign rel_burst  = xfer & ((|lane_last) | (cnt_q == LastCnt));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            ptr_q   <= PtrRst;
            lane_q  <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q <= StBusy;
                        grant_q <= N'(1) << pick_idx;
                        lane_q  <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                StBusy: begin
                    if (rel_burst) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                        lane_q  <= '0;
                        ptr_q   <= lane_q;
                        cnt_q   <= '0;
                    end else if (xfer) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.o_grant = grant_q;
    assign bus.o_valid = beat_valid;
    assign bus.o_data  = sel_data;
    assign bus.o_lane  = lane_q;
    assign bus.o_busy  = busy;

endmodule
